bist_response_analyzer: RTL

//   Response side of the BIST handshake. Consumes init/running/finish from the BIST sequencer.

---
 rtl/bist_response_analyzer.sv | 114 +++++++++++
 1 files changed

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: MISR compaction of CUT data, golden check at finish.
// Ports: clk/reset, init/running/finish handshake, cut_data in; signature, cycle_count, result_valid, pass, proto_err out.
module bist_response_analyzer #(
  parameter int              WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = 'hB400,
  parameter logic [WIDTH-1:0] SEED       = 'hFFFF,
  parameter logic [WIDTH-1:0] GOLDEN_SIG = 'h0000,
  parameter int              EXP_CYCLES = 650,
  localparam int             CW         = $clog2(EXP_CYCLES+1)+1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_data,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    cycle_count,
  output logic             result_valid,
  output logic             pass,
  output logic             proto_err
);

  typedef enum logic [2:0] {
    IDLE, ARMED, COMPACT, CHECK, DONE
  } state_t;

  localparam logic [CW-1:0] EXP_CNT = CW'(EXP_CYCLES);

  state_t           state, state_d;
  logic [WIDTH-1:0] sig_d, misr_next;
  logic [CW-1:0]    cnt_d, cnt_inc;
  logic             rv_d, pass_d, perr_d;
  logic             compact;

  assign misr_next = {signature[WIDTH-2:0], 1'b0}
                   ^ (signature[WIDTH-1] ? POLY : '0)
                   ^ cut_data;

  // All-ones count is the saturation point; it can never match EXP_CNT.
  assign cnt_inc = (&cycle_count) ? cycle_count
                                  : cycle_count + 1'b1;

  always_comb begin
    state_d = state;
    sig_d   = signature;
    cnt_d   = cycle_count;
    rv_d    = result_valid;
    pass_d  = pass;
    perr_d  = proto_err;
    compact = 1'b0;
    if (init) begin
      sig_d   = SEED;
      cnt_d   = '0;
      rv_d    = 1'b0;
      pass_d  = 1'b0;
      // Aborting an active run is itself a violation.
      perr_d  = (state == COMPACT);
      state_d = ARMED;
    end else begin
      unique case (state)
        IDLE: begin
          if (running || finish) perr_d = 1'b1;
        end
        ARMED: begin
          if (running) begin
            compact = 1'b1;
            state_d = finish ? CHECK : COMPACT;
          end else if (finish) begin
            state_d = CHECK;
          end
        end
        COMPACT: begin
          compact = running;
          if (finish) state_d = CHECK;
        end
        CHECK: begin
          pass_d  = (signature == GOLDEN_SIG)
                 && (cycle_count == EXP_CNT);
          rv_d    = 1'b1;
          state_d = DONE;
          if (running) perr_d = 1'b1;
        end
        DONE: begin
          if (running || finish) perr_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
      if (compact) begin
        sig_d = misr_next;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      signature    <= SEED;
      cycle_count  <= '0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state        <= state_d;
      signature    <= sig_d;
      cycle_count  <= cnt_d;
      result_valid <= rv_d;
      pass         <= pass_d;
      proto_err    <= perr_d;
    end
  end

endmodule
